// File: rtl/i2s_receiver.sv
// I2S capture path: oversamples bclk/lrclk/sdata in clk_soc, assembles 24-bit L/R pairs
// and buffers them in a first-word-fall-through FIFO read through a valid/ready handshake.
module i2s_receiver #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] frame_out_l,
    output logic [DATA_WIDTH-1:0] frame_out_r,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [FIFO_AW:0]      fill_level,
    output logic                  overflow,
    output logic                  short_slot,
    input  logic                  clear_errors
);

    localparam int unsigned CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam int unsigned DEPTH   = 2 ** FIFO_AW;
    localparam int unsigned FRAME_W = 2 * DATA_WIDTH;

    // Input synchronizers; all three lines share the same depth so they stay aligned
    logic bclk_s1, bclk_s2, bclk_s3;
    logic lr_s1, lr_s2;
    logic sd_s1, sd_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            lr_s1   <= 1'b0;
            lr_s2   <= 1'b0;
            sd_s1   <= 1'b0;
            sd_s2   <= 1'b0;
        end else begin
            bclk_s1 <= bclk;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            lr_s1   <= lrclk;
            lr_s2   <= lr_s1;
            sd_s1   <= sdata;
            sd_s2   <= sd_s1;
        end
    end

    logic                  bclk_rise;
    logic                  slot_start;
    logic                  bit_take;
    logic                  word_done;
    logic                  short_ev;
    logic [DATA_WIDTH-1:0] shift_next;

    logic                  lr_prev;
    logic                  channel;
    logic                  synced;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] left_word;
    logic                  have_left;
    logic                  frame_rdy;
    logic [FRAME_W-1:0]    frame_data;
    logic                  push_valid;
    logic [FRAME_W-1:0]    push_data;

    assign bclk_rise  = bclk_s2 & ~bclk_s3;
    assign slot_start = bclk_rise & (lr_s2 != lr_prev);
    assign bit_take   = bclk_rise & ~slot_start & synced & (bit_cnt < CNT_W'(DATA_WIDTH));
    assign word_done  = bit_take & (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign short_ev   = slot_start & synced & (bit_cnt < CNT_W'(DATA_WIDTH));
    assign shift_next = {shift_reg[DATA_WIDTH-2:0], sd_s2};

    // Slot tracking and word assembly; the bit on a slot-start edge belongs to the old slot
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_prev    <= 1'b0;
            channel    <= 1'b0;
            synced     <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            left_word  <= '0;
            have_left  <= 1'b0;
            frame_rdy  <= 1'b0;
            frame_data <= '0;
            push_valid <= 1'b0;
            push_data  <= '0;
        end else begin
            frame_rdy  <= 1'b0;
            push_valid <= frame_rdy;
            push_data  <= frame_data;
            if (slot_start) begin
                lr_prev <= lr_s2;
                channel <= lr_s2;
                bit_cnt <= '0;
                if (!lr_s2) begin
                    have_left <= 1'b0;
                end
                if (lr_prev && !lr_s2) begin
                    synced <= 1'b1;
                end
            end else if (bit_take) begin
                shift_reg <= shift_next;
                bit_cnt   <= bit_cnt + CNT_W'(1);
                if (word_done) begin
                    if (!channel) begin
                        left_word <= shift_next;
                        have_left <= 1'b1;
                    end else if (have_left) begin
                        frame_rdy  <= 1'b1;
                        frame_data <= {left_word, shift_next};
                        have_left  <= 1'b0;
                    end
                end
            end
        end
    end

    // FWFT FIFO; head registers are loaded from next-state so they track frame_valid exactly
    logic [FRAME_W-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] rd_next;
    logic [FIFO_AW:0]   count_next;
    logic [FRAME_W-1:0] head_next;
    logic               pop;
    logic               full;
    logic               do_write;
    logic               ovf_ev;

    always_comb begin
        pop        = frame_valid & frame_ready;
        full       = (fill_level == (FIFO_AW + 1)'(DEPTH));
        do_write   = push_valid & (~full | pop);
        ovf_ev     = push_valid & full & ~pop;
        rd_next    = pop ? rd_ptr + FIFO_AW'(1) : rd_ptr;
        count_next = fill_level;
        if (do_write && !pop) begin
            count_next = fill_level + (FIFO_AW + 1)'(1);
        end else if (!do_write && pop) begin
            count_next = fill_level - (FIFO_AW + 1)'(1);
        end
        head_next = mem[rd_next];
        if (do_write && (wr_ptr == rd_next)) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_level  <= '0;
            frame_valid <= 1'b0;
            frame_out_l <= '0;
            frame_out_r <= '0;
            overflow    <= 1'b0;
            short_slot  <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            rd_ptr      <= rd_next;
            fill_level  <= count_next;
            frame_valid <= (count_next != '0);
            if (count_next != '0) begin
                frame_out_l <= head_next[FRAME_W-1:DATA_WIDTH];
                frame_out_r <= head_next[DATA_WIDTH-1:0];
            end
            // A new event wins over a simultaneous clear
            overflow   <= (overflow & ~clear_errors) | ovf_ev;
            short_slot <= (short_slot & ~clear_errors) | short_ev;
        end
    end

endmodule
